// File: rtl/pcm_sample_streamer_pkg.sv
// Shared types and constants for the PCM sample streamer: fetch FSM states,
// DAC mid-scale level and parameter defaults.
package pcm_sample_streamer_pkg;

    typedef enum logic [1:0] {
        LO_REQ = 2'd0,
        LO_CAP = 2'd1,
        HI_REQ = 2'd2,
        HI_CAP = 2'd3
    } fetch_state_t;

    localparam logic [7:0]  DAC_MIDSCALE    = 8'h80;
    localparam int unsigned DEFAULT_CLK_DIV = 1134;
    localparam int unsigned DEFAULT_DEPTH   = 16;
    localparam int unsigned SAMPLE_W        = 16;

    // Signed 16-bit sample to unsigned 8-bit DAC level: keep the MSB byte, flip the sign.
    function automatic logic [7:0] to_dac_level(input logic [SAMPLE_W-1:0] s);
        return s[SAMPLE_W-1 -: 8] ^ DAC_MIDSCALE;
    endfunction

endpackage

// File: rtl/pcm_sample_streamer_if.sv
// Byte-read handshake between the streamer (master) and the SD controller
// read-data FIFO (slave); read data is valid the cycle after fifo_rd.
interface pcm_sample_streamer_if;

    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_data;

    modport master (
        output fifo_rd,
        input  fifo_empty,
        input  fifo_data
    );

    modport slave (
        input  fifo_rd,
        output fifo_empty,
        output fifo_data
    );

endinterface

// File: rtl/pcm_sample_streamer_sample_fifo.sv
// Synchronous sample FIFO: registered count/full/empty, head readable combinationally.
// Push when full and pop when empty are ignored.
module sample_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      count_next;

    always_comb begin
        do_push    = push && !full;
        do_pop     = pop && !empty;
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pcm_sample_streamer.sv
// Assembles little-endian 16-bit PCM samples from the SD read FIFO into a local
// buffer and releases one per sample period to the PWM DAC as an 8-bit level.
module pcm_sample_streamer
    import pcm_sample_streamer_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    pcm_sample_streamer_if.master        sd,
    output logic [7:0]                   val,
    output logic                         sample_tick,
    output logic                         underrun,
    output logic [$clog2(DEPTH):0]       level
);

    localparam int unsigned CW = $clog2(CLK_DIV);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic                  rd_req;
    logic                  push;
    logic                  pop;
    logic [7:0]            lo_byte;
    logic [SAMPLE_W-1:0]   push_data;
    logic [SAMPLE_W-1:0]   head;
    logic                  buf_full;
    logic                  buf_empty;
    logic [CW-1:0]         div_cnt;

    // A pair only starts when the buffer has room, so the later push never overflows.
    always_comb begin
        state_next = state;
        rd_req     = 1'b0;
        push       = 1'b0;
        case (state)
            LO_REQ: begin
                if (enable && !sd.fifo_empty && !buf_full) begin
                    rd_req     = 1'b1;
                    state_next = LO_CAP;
                end
            end
            LO_CAP: state_next = HI_REQ;
            HI_REQ: begin
                if (!sd.fifo_empty) begin
                    rd_req     = 1'b1;
                    state_next = HI_CAP;
                end
            end
            HI_CAP: begin
                push       = 1'b1;
                state_next = LO_REQ;
            end
            default: state_next = LO_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= LO_REQ;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst)                  lo_byte <= '0;
        else if (state == LO_CAP) lo_byte <= sd.fifo_data;
    end

    // Strobe is decoded from state; masking with rst keeps it low while in reset.
    assign sd.fifo_rd = rd_req && !rst;
    assign push_data  = {sd.fifo_data, lo_byte};

    assign sample_tick = enable && (div_cnt == CW'(CLK_DIV - 1));
    assign pop         = sample_tick && !buf_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            val      <= DAC_MIDSCALE;
            underrun <= 1'b0;
        end else begin
            if (!enable || sample_tick) div_cnt <= '0;
            else                        div_cnt <= div_cnt + 1'b1;
            if (sample_tick) begin
                if (!buf_empty) val      <= to_dac_level(head);
                else            underrun <= 1'b1;
            end
        end
    end

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_sample_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (level)
    );

endmodule

// File: tb/tb_pcm_sample_streamer.sv
// Directed and randomized checks of pcm_sample_streamer against an SD FIFO byte
// source and a sample-level expectation model kept in the bench.
module tb_pcm_sample_streamer;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] val;
    logic       sample_tick;
    logic       underrun;
    logic [2:0] level;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    pcm_sample_streamer_if sd();

    pcm_sample_streamer #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sd          (sd.master),
        .val         (val),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .level       (level)
    );

    always #5 clk = ~clk;

    // SD read FIFO model: bytes queued by the stimulus, one registered cycle of read latency.
    logic [7:0] src_mem [256];
    int src_wr = 0;
    int src_rd = 0;

    assign sd.fifo_empty = (src_wr == src_rd);

    always @(posedge clk) begin
        if (sd.fifo_rd === 1'b1) begin
            sd.fifo_data <= src_mem[src_rd % 256];
            src_rd       <= src_rd + 1;
        end
    end

    task automatic put(input logic [7:0] b);
        src_mem[src_wr % 256] = b;
        src_wr++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stops on the negedge where sample_tick is high; n = negedges waited.
    task automatic wait_tick(input string tag, output int n);
        n = 0;
        while (sample_tick !== 1'b1 && n < 4 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        if (sample_tick !== 1'b1) check({tag, "_tick_timeout"}, 32'(sample_tick), 32'd1);
    endtask

    function automatic logic [7:0] dac_of(input logic [15:0] s);
        return 8'(((32'(s) >> 8) ^ 32'h80) & 32'hFF);
    endfunction

    initial begin
        int n;
        int rd0;
        logic [7:0]  bytes [24];
        logic [15:0] exp_s [12];

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_val", 32'(val), 32'h80);
        check("reset_fifo_rd", 32'(sd.fifo_rd), 32'd0);
        check("reset_tick", 32'(sample_tick), 32'd0);
        check("reset_underrun", 32'(underrun), 32'd0);
        check("reset_level", 32'(level), 32'd0);

        // Two samples 0x1234, 0x5678; the second push coincides with the first pop
        put(8'h34); put(8'h12); put(8'h78); put(8'h56);
        rst = 1'b0;
        enable = 1'b1;
        wait_tick("t1a", n);
        check("t1_first_tick_delay", 32'(n), 32'(CLK_DIV - 1));
        @(negedge clk);
        check("t1_val0", 32'(val), 32'h92);
        check("t1_tick_pulse", 32'(sample_tick), 32'd0);
        check("t1_level_pushpop", 32'(level), 32'd1);
        wait_tick("t1b", n);
        @(negedge clk);
        check("t1_val1", 32'(val), 32'hD6);
        check("t1_underrun", 32'(underrun), 32'd0);
        check("t1_level_drained", 32'(level), 32'd0);

        // Empty source: val holds mid-scale, underrun sticks, no reads
        rst = 1'b1;
        @(negedge clk);
        check("t2_rst_val", 32'(val), 32'h80);
        rst = 1'b0;
        rd0 = src_rd;
        wait_tick("t2a", n);
        @(negedge clk);
        check("t2_underrun", 32'(underrun), 32'd1);
        check("t2_val", 32'(val), 32'h80);
        wait_tick("t2b", n);
        check("t2_period", 32'(n + 1), 32'(CLK_DIV));
        @(negedge clk);
        wait_tick("t2c", n);
        @(negedge clk);
        check("t2_val_hold", 32'(val), 32'h80);
        check("t2_underrun_sticky", 32'(underrun), 32'd1);
        check("t2_no_reads", 32'(src_rd - rd0), 32'd0);

        // Source runs dry between low and high byte; enable dropped while waiting
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        rd0 = src_rd;
        put(8'hCD);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        cycles(20);
        check("t3_single_read", 32'(src_rd - rd0), 32'd1);
        check("t3_level_wait", 32'(level), 32'd0);
        put(8'hAB);
        cycles(4);
        check("t3_two_reads", 32'(src_rd - rd0), 32'd2);
        check("t3_level_pushed", 32'(level), 32'd1);
        enable = 1'b1;
        wait_tick("t3", n);
        @(negedge clk);
        check("t3_val", 32'(val), 32'h2B);

        // Random samples: saturate the buffer with the divider held, then drain with refills
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 24; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 12; i++) exp_s[i] = {bytes[2*i+1], bytes[2*i]};
        rd0 = src_rd;
        for (int i = 0; i < 24; i++) put(bytes[i]);
        for (int i = 0; i < 8; i++) begin
            enable = 1'b1;
            cycles(6);
            enable = 1'b0;
            cycles(1);
        end
        check("t4_sat_level", 32'(level), 32'(DEPTH));
        check("t4_sat_reads", 32'(src_rd - rd0), 32'(2 * DEPTH));
        check("t4_no_tick_val", 32'(val), 32'h80);
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1;
            cycles(6);
            enable = 1'b0;
            cycles(1);
        end
        check("t4_reads_stopped", 32'(src_rd - rd0), 32'(2 * DEPTH));
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_tick("t4", n);
            check("t4_level_at_tick", 32'(level), 32'(DEPTH));
            @(negedge clk);
            check("t4_val", 32'(val), 32'(dac_of(exp_s[k])));
            check("t4_level_after_pop", 32'(level), 32'(DEPTH - 1));
            cycles(5);
            check("t4_level_refilled", 32'(level), 32'(DEPTH));
        end

        // Extremes of the signed range
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        src_wr = src_rd;
        put(8'h00); put(8'h80); put(8'hFF); put(8'h7F);
        enable = 1'b1;
        wait_tick("t5a", n);
        @(negedge clk);
        check("t5_val_min", 32'(val), 32'h00);
        wait_tick("t5b", n);
        @(negedge clk);
        check("t5_val_max", 32'(val), 32'hFF);
        wait_tick("t5c", n);
        @(negedge clk);
        check("t5_underrun", 32'(underrun), 32'd1);
        check("t5_val_hold", 32'(val), 32'hFF);

        // Reset while the low byte is being captured; pairing realigns to the next read
        enable = 1'b0;
        @(negedge clk);
        put(8'hA1); put(8'hB2); put(8'hC3);
        rd0 = src_rd;
        enable = 1'b1;
        @(negedge clk);
        check("t6_lo_read", 32'(src_rd - rd0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_val", 32'(val), 32'h80);
        check("t6_rst_underrun", 32'(underrun), 32'd0);
        check("t6_rst_level", 32'(level), 32'd0);
        check("t6_rst_fifo_rd", 32'(sd.fifo_rd), 32'd0);
        check("t6_rst_tick", 32'(sample_tick), 32'd0);
        rst = 1'b0;
        wait_tick("t6", n);
        @(negedge clk);
        check("t6_val_realigned", 32'(val), 32'h43);
        check("t6_reads", 32'(src_rd - rd0), 32'd3);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
